// File: rtl/ysyx_040066_div_iter.sv
// Iterative restoring divider for RV64M DIV/DIVU/REM/REMU and their W variants.
// Define YSYX_040066_DIV_RADIX4_EN to retire two quotient bits per CALC cycle.

module ysyx_040066_div_iter #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            block,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [1:0]      ALUctr,
    input  logic            is_w,
    output logic            busy,
    output logic            out_valid,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    typedef struct packed {
        logic [XLEN-1:0] rem;
        logic [XLEN-1:0] quo;
    } rq_t;

`ifdef YSYX_040066_DIV_RADIX4_EN
    localparam int STEPS = 2;
`else
    localparam int STEPS = 1;
`endif
    localparam logic [5:0] CNT_D = 6'(XLEN / STEPS - 1);
    localparam logic [5:0] CNT_W = 6'(32 / STEPS - 1);

    // W results are always sign-extended from bit 31, signed or not.
    function automatic logic [XLEN-1:0] fmt_w(input logic [XLEN-1:0] v, input logic w);
        return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
    endfunction

    function automatic rq_t div_step(input rq_t cur, input logic [XLEN-1:0] dvs);
        logic [XLEN:0] shifted;
        logic [XLEN:0] trial;
        rq_t           nxt;
        shifted  = {cur.rem, cur.quo[XLEN-1]};
        trial    = shifted - {1'b0, dvs};
        nxt.quo  = {cur.quo[XLEN-2:0], ~trial[XLEN]};
        nxt.rem  = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
        return nxt;
    endfunction

    state_t          state;
    logic [5:0]      cnt;
    rq_t             rq_q;
    rq_t             rq_nxt;
    logic [XLEN-1:0] dvs_q;
    logic            q_neg_q;
    logic            r_neg_q;
    logic            sel_rem_q;
    logic            is_w_q;
    logic [XLEN-1:0] result_q;

    // Accept-side operand conditioning.
    logic            op_signed;
    logic [XLEN-1:0] a_ext;
    logic [XLEN-1:0] b_ext;
    logic            s1;
    logic            s2;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic [XLEN-1:0] min_val;
    logic            div_zero;
    logic            ovf;
    logic [XLEN-1:0] sp_val;
    logic            accept;

    assign op_signed = ~ALUctr[0];
    assign a_ext     = is_w ? {{(XLEN-32){op_signed & src1[31]}}, src1[31:0]} : src1;
    assign b_ext     = is_w ? {{(XLEN-32){op_signed & src2[31]}}, src2[31:0]} : src2;
    assign s1        = op_signed & a_ext[XLEN-1];
    assign s2        = op_signed & b_ext[XLEN-1];
    assign a_abs     = s1 ? -a_ext : a_ext;
    assign b_abs     = s2 ? -b_ext : b_ext;
    assign min_val   = is_w ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    assign div_zero  = (b_ext == '0);
    assign ovf       = op_signed & (a_ext == min_val) & (&b_ext);
    assign sp_val    = ALUctr[1] ? (div_zero ? a_ext : '0) : (div_zero ? '1 : a_ext);
    assign accept    = (state == S_IDLE) && in_valid && !flush;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        rq_nxt = div_step(rq_q, dvs_q);
`ifdef YSYX_040066_DIV_RADIX4_EN
        rq_nxt = div_step(rq_nxt, dvs_q);
`endif
    end

    logic [XLEN-1:0] q_fin;
    logic [XLEN-1:0] r_fin;
    logic [XLEN-1:0] calc_result;

    assign q_fin       = q_neg_q ? -rq_nxt.quo : rq_nxt.quo;
    assign r_fin       = r_neg_q ? -rq_nxt.rem : rq_nxt.rem;
    assign calc_result = fmt_w(sel_rem_q ? r_fin : q_fin, is_w_q);

    // NOTE: datapath registers carry no reset; they are always written at accept before use.
    always_ff @(posedge clk) begin
        if (!block) begin
            if (accept) begin
                rq_q.rem  <= '0;
                rq_q.quo  <= is_w ? {a_abs[31:0], {(XLEN-32){1'b0}}} : a_abs;
                dvs_q     <= b_abs;
                q_neg_q   <= s1 ^ s2;
                r_neg_q   <= s1;
                sel_rem_q <= ALUctr[1];
                is_w_q    <= is_w;
            end else if (state == S_CALC) begin
                rq_q <= rq_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            result_q  <= '0;
        end else if (!block) begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        busy <= 1'b1;
                        if (div_zero || ovf) begin
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                            result_q  <= fmt_w(sp_val, is_w);
                        end else begin
                            state <= S_CALC;
                            cnt   <= is_w ? CNT_W : CNT_D;
                        end
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 6'd1;
                        if (cnt == '0) begin
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                            result_q  <= calc_result;
                        end
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_ysyx_040066_div_iter.sv
// Directed self-checking bench for ysyx_040066_div_iter: results, latency,
// special cases, block/flush/reset behaviour and accept boundaries.

module tb_ysyx_040066_div_iter;

    logic        clk;
    logic        rst;
    logic        block;
    logic        flush;
    logic        in_valid;
    logic [63:0] src1;
    logic [63:0] src2;
    logic [1:0]  ALUctr;
    logic        is_w;
    logic        busy;
    logic        out_valid;
    logic [63:0] result;

    int checks   = 0;
    int failures = 0;

`ifdef YSYX_040066_DIV_RADIX4_EN
    localparam int LAT_D = 32;
    localparam int LAT_W = 16;
`else
    localparam int LAT_D = 64;
    localparam int LAT_W = 32;
`endif

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    ysyx_040066_div_iter #(.XLEN(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .block     (block),
        .flush     (flush),
        .in_valid  (in_valid),
        .src1      (src1),
        .src2      (src2),
        .ALUctr    (ALUctr),
        .is_w      (is_w),
        .busy      (busy),
        .out_valid (out_valid),
        .result    (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for exactly one accepting edge.
    task automatic start(input logic [63:0] a, input logic [63:0] b,
                         input logic [1:0] op, input logic w);
        src1     = a;
        src2     = b;
        ALUctr   = op;
        is_w     = w;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Counts edges after accept until out_valid, bounded by a cycle budget.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [1:0] op, input logic w,
                          input int exp_lat, input logic [63:0] exp_res);
        int lat;
        start(a, b, op, w);
        wait_done(lat);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_res"}, result, exp_res);
        tick();
        check({tag, "_idle"}, {62'b0, busy, out_valid}, 64'd0);
    endtask

    initial begin
        int lat;

        rst      = 1'b1;
        block    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        src1     = '0;
        src2     = '0;
        ALUctr   = OP_DIV;
        is_w     = 1'b0;
        repeat (2) tick();
        check("reset_busy",   {63'b0, busy},      64'd0);
        check("reset_valid",  {63'b0, out_valid}, 64'd0);
        check("reset_result", result,             64'd0);
        rst = 1'b0;
        tick();

        run_op("divu_100_7",  64'd100, 64'd7, OP_DIVU, 1'b0, LAT_D, 64'd14);
        run_op("remu_100_7",  64'd100, 64'd7, OP_REMU, 1'b0, LAT_D, 64'd2);
        run_op("rem_m7_2",    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, OP_REM, 1'b0, LAT_D, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("div_m7_2",    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, OP_DIV, 1'b0, LAT_D, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div_100_m7",  64'd100, 64'hFFFF_FFFF_FFFF_FFF9, OP_DIV, 1'b0, LAT_D, 64'hFFFF_FFFF_FFFF_FFF2);
        run_op("div_5_0",     64'd5, 64'd0, OP_DIV, 1'b0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("rem_5_0",     64'd5, 64'd0, OP_REM, 1'b0, 0, 64'd5);
        run_op("div_ovf64",   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, OP_DIV, 1'b0,
               0, 64'h8000_0000_0000_0000);
        run_op("divw_ovf",    64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, OP_DIV, 1'b1,
               0, 64'hFFFF_FFFF_8000_0000);
        run_op("divuw_max_1", 64'h0000_0000_FFFF_FFFF, 64'd1, OP_DIVU, 1'b1, LAT_W, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("remw_m7_2",   64'h1234_5678_FFFF_FFF9, 64'd2, OP_REM, 1'b1, LAT_W, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("remuw_100_7", 64'hABCD_0000_0000_0064, 64'h5555_0000_0000_0007, OP_REMU, 1'b1, LAT_W, 64'd2);

        // Stall for 5 cycles mid-CALC, then hold DONE for 3 more.
        start(64'd100, 64'd7, OP_DIVU, 1'b0);
        repeat (10) tick();
        block = 1'b1;
        repeat (5) tick();
        check("blk_calc_busy",  {63'b0, busy},      64'd1);
        check("blk_calc_valid", {63'b0, out_valid}, 64'd0);
        block = 1'b0;
        wait_done(lat);
        check("blk_lat", 64'(15 + lat), 64'(LAT_D + 5));
        check("blk_res", result, 64'd14);
        block = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("blk_done_valid", {63'b0, out_valid}, 64'd1);
            check("blk_done_res",   result,             64'd14);
        end
        block = 1'b0;
        tick();
        check("blk_exit", {62'b0, busy, out_valid}, 64'd0);

        // Flush sampled at the cycle-10 edge, new request right after.
        start(64'd100, 64'd7, OP_DIVU, 1'b0);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_idle", {62'b0, busy, out_valid}, 64'd0);
        check("flush_res",  result, 64'd14);
        start(64'd9, 64'd3, OP_DIVU, 1'b0);
        check("post_flush_busy", {63'b0, busy}, 64'd1);
        wait_done(lat);
        check("post_flush_lat", 64'(lat), 64'(LAT_D));
        check("post_flush_res", result, 64'd3);
        tick();

        // in_valid together with flush in IDLE is not accepted.
        src1     = 64'd5;
        src2     = 64'd0;
        ALUctr   = OP_DIV;
        is_w     = 1'b0;
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_blocks_accept", {62'b0, busy, out_valid}, 64'd0);

        // in_valid held across DONE exit: no accept on the exit edge.
        src1     = 64'd5;
        src2     = 64'd0;
        ALUctr   = OP_REM;
        in_valid = 1'b1;
        tick();
        check("hold_first_done", {62'b0, busy, out_valid}, 64'd3);
        tick();
        check("hold_exit_idle",  {62'b0, busy, out_valid}, 64'd0);
        tick();
        in_valid = 1'b0;
        check("hold_reaccept",   {62'b0, busy, out_valid}, 64'd3);
        check("hold_reaccept_res", result, 64'd5);
        tick();

        // Reset mid-CALC overrides a simultaneous block.
        start(64'd100, 64'd7, OP_DIVU, 1'b0);
        repeat (5) tick();
        rst   = 1'b1;
        block = 1'b1;
        tick();
        check("rst_mid_busy",   {63'b0, busy},      64'd0);
        check("rst_mid_valid",  {63'b0, out_valid}, 64'd0);
        check("rst_mid_result", result,             64'd0);
        rst   = 1'b0;
        block = 1'b0;
        repeat (70) tick();
        check("rst_mid_stays_idle", {62'b0, busy, out_valid}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
